// File: rtl/pdp_csb_initiator_if.sv
// Host command, CSB request/response and completion signals of the PDP CSB initiator.
// The master modport is the initiator's view; slave is the view of whatever drives it.
interface pdp_csb_initiator_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [21:0] cmd_addr;
   logic [31:0] cmd_wdat;
   logic        cmd_write;
   logic        cmd_nposted;
   logic        csb_req_pvld;
   logic        csb_req_prdy;
   logic [62:0] csb_req_pd;
   logic        csb_resp_valid;
   logic [33:0] csb_resp_pd;
   logic        rsp_valid;
   logic [31:0] rsp_rdat;
   logic        rsp_error;
   logic        rsp_timeout;
   logic        spurious;

   modport master (
      input  cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
      input  csb_req_prdy, csb_resp_valid, csb_resp_pd,
      output cmd_ready, csb_req_pvld, csb_req_pd,
      output rsp_valid, rsp_rdat, rsp_error, rsp_timeout, spurious
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
      output csb_req_prdy, csb_resp_valid, csb_resp_pd,
      input  cmd_ready, csb_req_pvld, csb_req_pd,
      input  rsp_valid, rsp_rdat, rsp_error, rsp_timeout, spurious
   );
endinterface

// File: rtl/pdp_csb_initiator.sv
// Single-outstanding CSB request initiator for the PDP register ports, with a
// response timeout so that stubbed (never-responding) instances cannot hang the host.
module pdp_csb_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                 nvdla_core_clk,
   input logic                 nvdla_core_rst,
   pdp_csb_initiator_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   // level=0, wrbe=all bytes, srcpriv=0; nposted only meaningful for writes
   function automatic logic [62:0] pack_req(input logic [21:0] addr,
                                            input logic [31:0] wdat,
                                            input logic        write,
                                            input logic        nposted);
      pack_req = {2'b00, 4'hF, 1'b0, write & nposted, write, wdat, addr};
   endfunction

   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [62:0] pd_q, pd_d;
   logic        cmd_ready_q;
   logic        pvld_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdat_q, rsp_rdat_d;
   logic        rsp_error_q, rsp_error_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic        spurious_q, spurious_d;
   logic        req_write_s;
   logic        req_posted_s;

   assign req_write_s  = pd_q[54];
   assign req_posted_s = pd_q[54] & ~pd_q[55];

   // Next-state and completion-capture logic
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      pd_d          = pd_q;
      rsp_rdat_d    = rsp_rdat_q;
      rsp_error_d   = rsp_error_q;
      rsp_timeout_d = rsp_timeout_q;
      spurious_d    = spurious_q | (bus.csb_resp_valid & (state_q != ST_WAIT));
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               pd_d    = pack_req(bus.cmd_addr, bus.cmd_wdat, bus.cmd_write, bus.cmd_nposted);
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.csb_req_prdy) begin
               if (req_posted_s) begin
                  state_d       = ST_DONE;
                  rsp_rdat_d    = 32'd0;
                  rsp_error_d   = 1'b0;
                  rsp_timeout_d = 1'b0;
               end else begin
                  state_d = ST_WAIT;
                  timer_d = 16'd0;
               end
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            // a response on the final timer cycle takes precedence over the timeout
            if (bus.csb_resp_valid) begin
               state_d       = ST_DONE;
               rsp_rdat_d    = req_write_s ? 32'd0 : bus.csb_resp_pd[31:0];
               rsp_error_d   = bus.csb_resp_pd[32] | (bus.csb_resp_pd[33] ^ req_write_s);
               rsp_timeout_d = 1'b0;
            end else if (timer_q == TMO_LAST) begin
               state_d       = ST_DONE;
               rsp_rdat_d    = 32'd0;
               rsp_error_d   = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, timer and registered outputs
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state_q       <= ST_IDLE;
         timer_q       <= 16'd0;
         pd_q          <= 63'd0;
         cmd_ready_q   <= 1'b1;
         pvld_q        <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdat_q    <= 32'd0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         spurious_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         pd_q          <= pd_d;
         cmd_ready_q   <= (state_d == ST_IDLE);
         pvld_q        <= (state_d == ST_REQ);
         rsp_valid_q   <= (state_d == ST_DONE);
         rsp_rdat_q    <= rsp_rdat_d;
         rsp_error_q   <= rsp_error_d;
         rsp_timeout_q <= rsp_timeout_d;
         spurious_q    <= spurious_d;
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.csb_req_pvld = pvld_q;
   assign bus.csb_req_pd   = pd_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_rdat     = rsp_rdat_q;
   assign bus.rsp_error    = rsp_error_q;
   assign bus.rsp_timeout  = rsp_timeout_q;
   assign bus.spurious     = spurious_q;

endmodule

// File: tb/tb_pdp_csb_initiator.sv
// Bench for pdp_csb_initiator: a per-cycle timeline of inputs and expected outputs is
// planned from transaction-level timing rules, then driven and compared cycle by cycle.
module tb_pdp_csb_initiator;
   localparam int TMO  = 16;
   localparam int MAXC = 6000;

   logic clk = 1'b1;
   logic rst = 1'b1;

   pdp_csb_initiator_if bus_if();

   pdp_csb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .nvdla_core_clk(clk),
      .nvdla_core_rst(rst),
      .bus           (bus_if)
   );

   always #5 clk = ~clk;

   // planned inputs, indexed by cycle
   bit          in_cmd_v [MAXC];
   logic [21:0] in_addr  [MAXC];
   logic [31:0] in_wdat  [MAXC];
   bit          in_write [MAXC];
   bit          in_np    [MAXC];
   bit          in_prdy  [MAXC];
   bit          in_rv    [MAXC];
   logic [33:0] in_rpd   [MAXC];
   bit          in_rst   [MAXC];
   // expected outputs, indexed by cycle
   bit          e_ready  [MAXC];
   bit          e_pvld   [MAXC];
   logic [62:0] e_pd     [MAXC];
   bit          e_rv     [MAXC];
   logic [31:0] e_rdat   [MAXC];
   bit          e_err    [MAXC];
   bit          e_tmo    [MAXC];
   bit          e_wait   [MAXC];
   bit          e_spur   [MAXC];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int ncyc   = 0;
   bit run    = 1'b0;

   int p_rd_c = -100, p_rd_d = -100, p_pw_c = -100, p_to_w = -100;
   int p_sp = -100, p_ab_x = -100, p_bd_d = -100;

   function automatic bit live(input int k, input int ab);
      return (ab < 0) || (k < ab);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // One command: accepted at c, stalled for 'stall' cycles, answered 'dly' cycles after
   // WAIT entry (dly >= TMO means never answered). abort_sel: -1 none, 0 random, >0 WAIT+n.
   task automatic plan_tx(input int c, input logic [21:0] a, input logic [31:0] wd,
                          input bit wr, input bit np, input int stall, input int dly,
                          input logic [33:0] rpd, input int late, input int abort_sel,
                          output int nxt, output int done_c, output int wait_c);
      int h, w, r, d, ab;
      logic [62:0] pd;
      logic [31:0] rd;
      bit er, to, posted;
      pd     = {2'b00, 4'hF, 1'b0, wr & np, wr, wd, a};
      posted = wr & ~np;
      h = c + 1 + stall;
      w = h + 1;
      r = -1;
      if (posted) begin
         d = h + 1; rd = 32'd0; er = 1'b0; to = 1'b0;
      end else if (dly < TMO) begin
         r  = w + dly;
         d  = r + 1;
         rd = wr ? 32'd0 : rpd[31:0];
         er = rpd[32] | (rpd[33] != wr);
         to = 1'b0;
      end else begin
         d = w + TMO; rd = 32'd0; er = 1'b1; to = 1'b1;
      end
      if (abort_sel > 0) ab = w + abort_sel;
      else if (abort_sel == 0) ab = int'($urandom_range(d, c + 1));
      else ab = -1;
      if (live(c, ab)) begin
         in_cmd_v[c] = 1'b1; in_addr[c] = a; in_wdat[c] = wd; in_write[c] = wr; in_np[c] = np;
      end
      for (int k = c + 1; k <= h; k++) begin
         if (live(k, ab)) begin
            in_prdy[k] = (k == h); e_pvld[k] = 1'b1; e_pd[k] = pd;
         end
      end
      for (int k = w; k < d; k++) if (live(k, ab)) e_wait[k] = 1'b1;
      for (int k = c + 1; k <= d; k++) begin
         if (live(k, ab)) begin
            e_ready[k] = 1'b0;
            if ($urandom_range(3, 0) == 0) in_cmd_v[k] = 1'b1;
         end
      end
      if (r >= 0 && live(r, ab)) begin
         in_rv[r] = 1'b1; in_rpd[r] = rpd;
      end
      if (live(d, ab)) begin
         e_rv[d] = 1'b1; e_rdat[d] = rd; e_err[d] = er; e_tmo[d] = to;
      end
      nxt = d + 1;
      if (ab >= 0) begin
         in_rst[ab] = 1'b1;
         nxt = ab + 2;
      end else if (late >= 0 && !posted && r < 0) begin
         in_rv[d + late]  = 1'b1;
         in_rpd[d + late] = {2'b00, 32'($urandom)};
         nxt = d + late + 1;
      end
      done_c = d;
      wait_c = w;
   endtask

   task automatic apply(input int k);
      rst                   = in_rst[k];
      bus_if.cmd_valid      = in_cmd_v[k];
      bus_if.cmd_addr       = in_addr[k];
      bus_if.cmd_wdat       = in_wdat[k];
      bus_if.cmd_write      = in_write[k];
      bus_if.cmd_nposted    = in_np[k];
      bus_if.csb_req_prdy   = in_prdy[k];
      bus_if.csb_resp_valid = in_rv[k];
      bus_if.csb_resp_pd    = in_rpd[k];
   endtask

   // Planning, then cycle-by-cycle stimulus
   initial begin
      int c, nxt, dd, ww, g, sel, dly, stall, late, ab, ntx;
      bit wr, np, s;
      logic [33:0] rpd;
      for (int k = 0; k < MAXC; k++) begin
         in_cmd_v[k] = 1'b0; in_addr[k] = 22'($urandom); in_wdat[k] = $urandom;
         in_write[k] = 1'($urandom); in_np[k] = 1'($urandom); in_prdy[k] = 1'($urandom);
         in_rv[k] = 1'b0; in_rpd[k] = {2'($urandom), 32'($urandom)}; in_rst[k] = 1'b0;
         e_ready[k] = 1'b1; e_pvld[k] = 1'b0; e_pd[k] = 63'd0; e_rv[k] = 1'b0;
         e_rdat[k] = 32'd0; e_err[k] = 1'b0; e_tmo[k] = 1'b0; e_wait[k] = 1'b0; e_spur[k] = 1'b0;
      end
      in_rst[0] = 1'b1;
      c = 3;
      p_rd_c = c;
      plan_tx(c, 22'h0000D0, 32'h0, 1'b0, 1'b0, 0, 3, {2'b00, 32'hDEADBEEF}, -1, -1, nxt, p_rd_d, ww);
      c = nxt + 1;
      p_pw_c = c;
      plan_tx(c, 22'h000012, 32'h5A5A0001, 1'b1, 1'b0, 4, 0, 34'd0, -1, -1, nxt, dd, ww);
      c = nxt + 1;
      plan_tx(c, 22'h000040, 32'h11112222, 1'b1, 1'b1, 0, TMO, 34'd0, -1, -1, nxt, dd, p_to_w);
      c = nxt + 1;
      plan_tx(c, 22'h000041, 32'h0, 1'b0, 1'b0, 1, 2, {2'b10, 32'hCAFE0001}, -1, -1, nxt, dd, ww);
      c = nxt + 1;
      plan_tx(c, 22'h000042, 32'h33334444, 1'b1, 1'b1, 0, 1, {2'b11, 32'h0}, -1, -1, nxt, dd, ww);
      c = nxt + 1;
      p_sp = c;
      in_rv[c] = 1'b1; in_rpd[c] = {2'b00, 32'h12345678};
      c = c + 2;
      plan_tx(c, 22'h000043, 32'h0, 1'b0, 1'b0, 0, TMO, 34'd0, 0, -1, nxt, dd, ww);
      c = nxt + 1;
      plan_tx(c, 22'h000044, 32'h0, 1'b0, 1'b0, 0, 0, {2'b00, 32'h0BADBEEF}, -1, -1, nxt, dd, ww);
      c = nxt + 1;
      plan_tx(c, 22'h000045, 32'h0, 1'b0, 1'b0, 0, 40, 34'd0, -1, 3, nxt, dd, ww);
      p_ab_x = ww + 3;
      c = nxt + 1;
      plan_tx(c, 22'h000046, 32'h0, 1'b0, 1'b0, 2, TMO - 1, {2'b00, 32'h600DF00D}, -1, -1, nxt, p_bd_d, ww);
      c = nxt + 1;
      ntx = 0;
      while (c < MAXC - 100 && ntx < 150) begin
         wr    = 1'($urandom);
         np    = 1'($urandom);
         stall = ($urandom_range(2, 0) == 0) ? int'($urandom_range(5, 1)) : 0;
         sel   = int'($urandom_range(7, 0));
         dly   = (sel == 0) ? TMO + int'($urandom_range(3, 0)) :
                 (sel == 1) ? TMO - 1 : int'($urandom_range(6, 0));
         rpd   = {wr ^ ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0), 32'($urandom)};
         late  = (dly >= TMO && $urandom_range(1, 0) == 1) ? int'($urandom_range(2, 0)) : -1;
         ab    = ($urandom_range(15, 0) == 0) ? 0 : -1;
         plan_tx(c, 22'($urandom), $urandom, wr, np, stall, dly, rpd, late, ab, nxt, dd, ww);
         g = int'($urandom_range(3, 0));
         for (int k = nxt; k < nxt + g; k++) begin
            if ($urandom_range(7, 0) == 0) in_rv[k] = 1'b1;
         end
         c = nxt + g;
         ntx++;
      end
      ncyc = c + 5;
      s = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         if (in_rst[k]) begin
            e_spur[k] = 1'b0; s = 1'b0;
         end else begin
            e_spur[k] = s;
            s = s | (in_rv[k] & ~e_wait[k]);
         end
      end
      run = 1'b1;
      apply(0);
      for (int k = 1; k < ncyc; k++) begin
         @(posedge clk);
         #1;
         cyc = k;
         apply(k);
      end
      @(posedge clk);
      run = 1'b0;
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Per-cycle comparison against the planned timeline, plus literal pins
   always @(negedge clk) begin
      if (run && cyc >= 1 && cyc < ncyc) begin
         chk("cmd_ready", 64'(bus_if.cmd_ready), 64'(e_ready[cyc]));
         chk("req_pvld", 64'(bus_if.csb_req_pvld), 64'(e_pvld[cyc]));
         if (e_pvld[cyc]) chk("req_pd", 64'(bus_if.csb_req_pd), 64'(e_pd[cyc]));
         chk("rsp_valid", 64'(bus_if.rsp_valid), 64'(e_rv[cyc]));
         if (e_rv[cyc]) begin
            chk("rsp_rdat", 64'(bus_if.rsp_rdat), 64'(e_rdat[cyc]));
            chk("rsp_error", 64'(bus_if.rsp_error), 64'(e_err[cyc]));
            chk("rsp_timeout", 64'(bus_if.rsp_timeout), 64'(e_tmo[cyc]));
         end
         chk("spurious", 64'(bus_if.spurious), 64'(e_spur[cyc]));
         if (cyc == 1) begin
            chk("pin_rst_ready", 64'(bus_if.cmd_ready), 64'd1);
            chk("pin_rst_pd", 64'(bus_if.csb_req_pd), 64'd0);
            chk("pin_rst_rdat", 64'(bus_if.rsp_rdat), 64'd0);
            chk("pin_rst_err_tmo", 64'({bus_if.rsp_error, bus_if.rsp_timeout}), 64'd0);
         end
         if (cyc == p_rd_c + 1) begin
            chk("pin_rd_addr", 64'(bus_if.csb_req_pd[21:0]), 64'h0D0);
            chk("pin_rd_write", 64'(bus_if.csb_req_pd[54]), 64'd0);
         end
         if (cyc == p_rd_d) begin
            chk("pin_rd_valid", 64'(bus_if.rsp_valid), 64'd1);
            chk("pin_rd_rdat", 64'(bus_if.rsp_rdat), 64'hDEADBEEF);
         end
         if (cyc >= p_pw_c + 1 && cyc <= p_pw_c + 5) begin
            chk("pin_pw_pd", 64'(bus_if.csb_req_pd),
                64'({2'b00, 4'hF, 1'b0, 1'b0, 1'b1, 32'h5A5A0001, 22'h000012}));
         end
         if (cyc == p_pw_c + 6) begin
            chk("pin_pw_done", 64'({bus_if.rsp_valid, bus_if.rsp_error}), 64'b10);
         end
         if (cyc == p_to_w + 16) begin
            chk("pin_to_done", 64'({bus_if.rsp_valid, bus_if.rsp_error, bus_if.rsp_timeout}), 64'b111);
            chk("pin_to_rdat", 64'(bus_if.rsp_rdat), 64'd0);
         end
         if (cyc == p_sp + 1) chk("pin_spur_set", 64'(bus_if.spurious), 64'd1);
         if (cyc == p_ab_x) begin
            chk("pin_abort", 64'({bus_if.csb_req_pvld, bus_if.rsp_valid, bus_if.cmd_ready, bus_if.spurious}),
                64'b0010);
         end
         if (cyc == p_bd_d) begin
            chk("pin_bd_done", 64'({bus_if.rsp_valid, bus_if.rsp_timeout}), 64'b10);
            chk("pin_bd_rdat", 64'(bus_if.rsp_rdat), 64'h600DF00D);
         end
      end
   end

endmodule
